// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: valid/ready command front end for the single-port RAM, with an optional
// array clear after reset and a 2-entry back-pressurable read response buffer.
module ram_sp_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATAWIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 init_done,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic                 ram_we,
    output logic [DATAWIDTH-1:0] ram_wr_data,
    input  logic [DATAWIDTH-1:0] ram_rd_data
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t               r_state, w_next;
    logic [ADDRWIDTH-1:0] r_clr_addr;
    logic                 r_init_done, r_pending, r_wr_ptr, r_rd_ptr;
    logic [1:0]           r_occ, w_occ_next, w_committed;
    logic [DATAWIDTH-1:0] r_mem0, r_mem1;
    logic                 w_clear, w_run, w_clr_last, w_push, w_pop, w_rd_ok, w_rd_acc;

    assign w_clear     = r_state == CLEAR;
    assign w_run       = r_state == RUN;
    assign w_clr_last  = r_clr_addr == '1;
    assign rsp_valid   = r_occ != 2'd0;
    assign rsp_data    = r_rd_ptr ? r_mem1 : r_mem0;
    assign init_done   = r_init_done;
    assign w_push      = r_pending;
    assign w_pop       = rsp_valid & rsp_ready;
    // committed counts every accepted read not yet popped, so the buffer can never overflow
    assign w_committed = r_occ + {1'b0, r_pending};
    assign w_rd_ok     = (w_committed < 2'd2) | ((w_committed == 2'd2) & w_pop);
    assign w_rd_acc    = req_valid & req_ready & ~req_we;
    assign w_occ_next  = (w_push & ~w_pop) ? r_occ + 2'd1 :
                         (~w_push & w_pop) ? r_occ - 2'd1 : r_occ;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? ((CLEAR_ON_RESET != 0) ? CLEAR : RUN) :
                 (w_clear && !w_clr_last) ? CLEAR : RUN;
    end

    always_comb begin
        req_ready   = w_run & (req_we | w_rd_ok);
        ram_we      = w_clear | (w_run & req_valid & req_we);
        ram_addr    = w_clear ? r_clr_addr : req_addr;
        ram_wr_data = w_clear ? CLEAR_VALUE : req_wdata;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_clr_addr  <= '0;
            r_init_done <= (CLEAR_ON_RESET == 0);
            r_pending   <= 1'b0;
            r_occ       <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_mem0      <= '0;
            r_mem1      <= '0;
        end else begin
            if (w_clear) r_clr_addr <= r_clr_addr + ADDRWIDTH'(1);
            if (w_clear && w_clr_last) r_init_done <= 1'b1;
            r_pending <= w_rd_acc;
            r_occ     <= w_occ_next;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
                if (r_wr_ptr) r_mem1 <= ram_rd_data;
                else          r_mem0 <= ram_rd_data;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_l)
        !(w_push && !w_pop && r_occ == 2'd2));
endmodule

// File: tb/tb_ram_sp_ctrl.sv
// tb_ram_sp_ctrl: directed stimulus against a queue-based model of ram_sp_ctrl plus a RAM model.
module tb_ram_sp_ctrl;
    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       reset_l = 1'b1;
    logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [8:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, init_done, ram_we;
    logic [7:0] rsp_data, ram_wr_data, ram_rd_data;
    logic [8:0] ram_addr;

    logic       n_req_ready, n_rsp_valid, n_init_done, n_ram_we;
    logic [7:0] n_rsp_data, n_ram_wr_data;
    logic [8:0] n_ram_addr;
    logic [7:0] n_rd = 8'h00;
    logic       n_rsp_ready = 1'b1;

    int n_vec = 0, n_fail = 0, pops = 0;

    ram_sp_ctrl dut (
        .clk(clk), .reset_l(reset_l), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    ram_sp_ctrl #(.CLEAR_ON_RESET(0)) dut_nc (
        .clk(clk), .reset_l(reset_l), .req_valid(req_valid), .req_ready(n_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_data(n_rsp_data),
        .init_done(n_init_done), .ram_addr(n_ram_addr), .ram_we(n_ram_we),
        .ram_wr_data(n_ram_wr_data), .ram_rd_data(n_rd)
    );

    always #5 clk = ~clk;

    // RAM with registered read data; starts non-zero so the clear is observable
    logic [7:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'hEE;
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wr_data;
        ram_rd_data <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: cycle index since reset release, memory image, queue of unpopped reads
    int         m_cyc = 0;
    logic [7:0] m_mem [DEPTH];
    logic [7:0] exp_q[$];
    int         acc_q[$];

    always @(negedge clk) begin
        if (!reset_l) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_init_done", 32'(init_done), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_ram_we", 32'(ram_we), 0);
            m_cyc = 0;
            exp_q.delete();
            acc_q.delete();
        end else begin
            logic m_clr, m_run, e_rv, e_rdy, e_we;
            int   n;
            m_clr = m_cyc >= 1 && m_cyc <= DEPTH;
            m_run = m_cyc > DEPTH;
            n     = acc_q.size();
            e_rv  = n > 0 && acc_q[0] + 2 <= m_cyc;
            e_rdy = m_run && (req_we || n < 2 || (n == 2 && e_rv && rsp_ready));
            e_we  = m_clr || (req_valid && e_rdy && req_we);
            chk("init_done", 32'(init_done), 32'(m_run));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            if (m_clr) begin
                chk("clr_addr", 32'(ram_addr), 32'(m_cyc - 1));
                chk("clr_data", 32'(ram_wr_data), 0);
                m_mem[m_cyc - 1] = 8'h00;
            end
            if (m_run) begin
                chk("run_addr", 32'(ram_addr), 32'(req_addr));
                chk("run_wdata", 32'(ram_wr_data), 32'(req_wdata));
            end
            if (e_rv) chk("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
            if (e_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                pops++;
            end
            if (req_valid && e_rdy) begin
                if (req_we) m_mem[req_addr] = req_wdata;
                else begin
                    exp_q.push_back(m_mem[req_addr]);
                    acc_q.push_back(m_cyc);
                end
            end
            m_cyc++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [8:0] a, input logic [7:0] d, output int waited);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            cyc();
        end
        chk("send_accept", 32'(waited < 20), 1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input logic [7:0] d);
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            cyc();
        end
        chk({nm, "_seen"}, 32'(i < 20), 1);
        if (i < 20) chk(nm, 32'(rsp_data), 32'(d));
        cyc();
    endtask

    initial begin
        int w, wsum, p0, we_cnt;
        #1 reset_l = 1'b0;
        #1;
        chk("lit_rst_init_done", 32'(init_done), 0);
        chk("lit_nc_rst_init_done", 32'(n_init_done), 1);
        repeat (3) @(posedge clk);
        #1 reset_l = 1'b1;
        @(negedge clk);
        chk("lit_idle_ram_we", 32'(ram_we), 0);
        chk("lit_nc_idle_ram_we", 32'(n_ram_we), 0);
        chk("lit_nc_idle_ready", 32'(n_req_ready), 0);
        we_cnt = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc();
            @(negedge clk);
            if (i == 1) begin
                chk("lit_nc_ready_c1", 32'(n_req_ready), 1);
                chk("lit_nc_init_done", 32'(n_init_done), 1);
            end
            we_cnt += 32'(ram_we);
        end
        cyc();
        @(negedge clk);
        chk("lit_clear_writes", 32'(we_cnt), 512);
        chk("lit_init_done_513", 32'(init_done), 1);
        chk("lit_ready_513", 32'(req_ready), 1);
        cyc();

        send(1'b0, 9'h1FF, 8'h00, w);
        wait_rsp("lit_rd_1ff", 8'h00);

        send(1'b1, 9'd3, 8'hA5, w);
        send(1'b0, 9'd3, 8'h00, w);
        @(negedge clk);
        chk("lit_lat_n1", 32'(rsp_valid), 0);
        cyc();
        @(negedge clk);
        chk("lit_lat_n2", 32'(rsp_valid), 1);
        chk("lit_wr_rd_a5", 32'(rsp_data), 32'h A5);
        cyc();

        for (int a = 0; a < 16; a++) send(1'b1, 9'(a), 8'(a) ^ 8'h3C, w);
        p0 = pops;
        wsum = 0;
        for (int a = 0; a < 16; a++) begin
            send(1'b0, 9'(a), 8'h00, w);
            wsum += w;
        end
        repeat (4) cyc();
        chk("lit_b2b_stalls", 32'(wsum), 0);
        chk("lit_b2b_pops", 32'(pops - p0), 16);

        rsp_ready = 1'b0;
        send(1'b0, 9'd5, 8'h00, w);
        send(1'b0, 9'd6, 8'h00, w);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'd7;
        @(negedge clk);
        chk("lit_third_stall", 32'(req_ready), 0);
        cyc();
        req_we = 1'b1; req_addr = 9'd100; req_wdata = 8'h77;
        @(negedge clk);
        chk("lit_stall_wr_ready", 32'(req_ready), 1);
        chk("lit_stall_wr_we", 32'(ram_we), 1);
        cyc();
        req_we = 1'b0; req_addr = 9'd7;
        @(negedge clk);
        chk("lit_third_stall2", 32'(req_ready), 0);
        chk("lit_buf_valid", 32'(rsp_valid), 1);
        cyc();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("lit_third_acc", 32'(req_ready), 1);
        chk("lit_first_pop", 32'(rsp_data), 32'h39);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lit_second_pop", 32'(rsp_data), 32'h3A);
        cyc();
        wait_rsp("lit_third_rsp", 8'h3B);
        send(1'b0, 9'd100, 8'h00, w);
        wait_rsp("lit_rd_100", 8'h77);

        rsp_ready = 1'b0;
        send(1'b0, 9'd8, 8'h00, w);
        send(1'b0, 9'd9, 8'h00, w);
        repeat (3) cyc();
        @(negedge clk);
        chk("lit_pre_rst_valid", 32'(rsp_valid), 1);
        @(posedge clk);
        #2 reset_l = 1'b0;
        #1;
        chk("lit_async_rsp_valid", 32'(rsp_valid), 0);
        chk("lit_async_init_done", 32'(init_done), 0);
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("lit_idle2_ram_we", 32'(ram_we), 0);
        cyc();
        @(negedge clk);
        chk("lit_clr_restart_we", 32'(ram_we), 1);
        chk("lit_clr_restart_addr", 32'(ram_addr), 0);
        repeat (DEPTH) cyc();
        @(negedge clk);
        chk("lit_reinit_done", 32'(init_done), 1);
        chk("lit_no_stale", 32'(rsp_valid), 0);
        cyc();
        send(1'b0, 9'd3, 8'h00, w);
        wait_rsp("lit_rd3_cleared", 8'h00);
        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
